db_arb: RTL and testbench

DB_ARB -- requirements
Module: db_arb

---
 rtl/db_pkg.sv | 25 ++
 rtl/db_arb_if.sv | 63 ++++++
 rtl/db_rr_arb2.sv | 34 +++
 rtl/db_arb.sv | 151 +++++++++++++++
 tb/tb_db_arb.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/db_pkg.sv
// Shared definitions for the two-port hash-table request arbiter: op encodings,
// table entry states, flag width and the arbiter FSM encoding.
package db_pkg;

    localparam logic SET_REQ = 1'b1;
    localparam logic GET_REQ = 1'b0;

    localparam logic [1:0] IDLE_STATE    = 2'b00;
    localparam logic [1:0] SUSPECT_STATE = 2'b01;
    localparam logic [1:0] ARREST_STATE  = 2'b10;
    localparam logic [1:0] EXPIRE_STATE  = 2'b11;

    localparam int FLAG_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_WAIT  = 2'b10
    } arb_state_e;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/db_arb_if.sv
// Request, response and table-side bus for db_arb. The arbiter connects to the
// slave modport; requesters and the table model drive the master side.
interface db_arb_if #(
    parameter int HASH_SIZE = 32,
    parameter int KEY_SIZE  = 96,
    parameter int VAL_SIZE  = 32
);
    import db_pkg::*;

    logic                 p0_valid;
    logic                 p0_ready;
    logic [3:0]           p0_op;
    logic [HASH_SIZE-1:0] p0_hash;
    logic [KEY_SIZE-1:0]  p0_key;
    logic [VAL_SIZE-1:0]  p0_value;

    logic                 p1_valid;
    logic                 p1_ready;
    logic [3:0]           p1_op;
    logic [HASH_SIZE-1:0] p1_hash;
    logic [KEY_SIZE-1:0]  p1_key;
    logic [VAL_SIZE-1:0]  p1_value;

    logic                 r0_valid;
    logic [FLAG_W-1:0]    r0_flag;
    logic [VAL_SIZE-1:0]  r0_value;
    logic                 r0_miss;

    logic                 r1_valid;
    logic [FLAG_W-1:0]    r1_flag;
    logic [VAL_SIZE-1:0]  r1_value;
    logic                 r1_miss;

    logic                 db_valid;
    logic [3:0]           db_op;
    logic [HASH_SIZE-1:0] db_hash;
    logic [KEY_SIZE-1:0]  db_key;
    logic [VAL_SIZE-1:0]  db_value;
    logic                 db_out_valid;
    logic [FLAG_W-1:0]    db_out_flag;
    logic [VAL_SIZE-1:0]  db_out_value;

    modport slave (
        input  p0_valid, p0_op, p0_hash, p0_key, p0_value,
        input  p1_valid, p1_op, p1_hash, p1_key, p1_value,
        output p0_ready, p1_ready,
        output r0_valid, r0_flag, r0_value, r0_miss,
        output r1_valid, r1_flag, r1_value, r1_miss,
        output db_valid, db_op, db_hash, db_key, db_value,
        input  db_out_valid, db_out_flag, db_out_value
    );

    modport master (
        output p0_valid, p0_op, p0_hash, p0_key, p0_value,
        output p1_valid, p1_op, p1_hash, p1_key, p1_value,
        input  p0_ready, p1_ready,
        input  r0_valid, r0_flag, r0_value, r0_miss,
        input  r1_valid, r1_flag, r1_value, r1_miss,
        input  db_valid, db_op, db_hash, db_key, db_value,
        output db_out_valid, db_out_flag, db_out_value
    );

endinterface

// File: rtl/db_rr_arb2.sv
// Two-way round-robin grant: a lone requester wins, a tie goes to the port not
// granted last. last_grant starts at 1 so port 0 wins the first tie.
module db_rr_arb2 (
    input  logic       clk156,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       en,
    input  logic       upd,
    output logic [1:0] gnt
);

    logic last_grant;

    always_comb begin
        gnt = 2'b00;
        if (en) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = last_grant ? 2'b01 : 2'b10;
                default: gnt = 2'b00;
            endcase
        end
    end

    always_ff @(posedge clk156) begin
        if (rst) begin
            last_grant <= 1'b1;
        end else if (upd) begin
            last_grant <= gnt[1];
        end
    end

endmodule

// File: rtl/db_arb.sv
// db_arb: shares one hash-table port between two requesters, one slot per request.
// Optional statistics counters are built only when DB_ARB_STATS_EN is defined.
module db_arb
    import db_pkg::*;
#(
    parameter int HASH_SIZE   = 32,
    parameter int KEY_SIZE    = 96,
    parameter int VAL_SIZE    = 32,
    parameter int SLOT_CYCLES = 5
) (
    input  logic        clk156,
    input  logic        rst,
    db_arb_if.slave     bus,
    output logic [31:0] stat_grant0,
    output logic [31:0] stat_grant1,
    output logic [15:0] stat_stray
);

    arb_state_e state, state_nxt;
    logic [1:0] gnt;
    logic       hs;
    logic [7:0] cnt;
    logic       owner;
    logic       got_rsp;
    logic       rsp_take;
    logic       miss_take;

    db_rr_arb2 u_rr (
        .clk156 (clk156),
        .rst    (rst),
        .req    ({bus.p1_valid, bus.p0_valid}),
        .en     (state == ST_IDLE),
        .upd    (hs),
        .gnt    (gnt)
    );

    assign bus.p0_ready = gnt[0];
    assign bus.p1_ready = gnt[1];
    assign hs = (bus.p0_valid & gnt[0]) | (bus.p1_valid & gnt[1]);

    // Only the first table response of a slot is taken; a miss is reported on
    // the last WAIT cycle when nothing has arrived (not even on that cycle).
    assign rsp_take  = (state == ST_WAIT) && bus.db_out_valid && !got_rsp;
    assign miss_take = (state == ST_WAIT) && (cnt == 8'd0) && !got_rsp && !bus.db_out_valid;

    always_ff @(posedge clk156) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (hs) state_nxt = ST_ISSUE;
            ST_ISSUE: state_nxt = ST_WAIT;
            ST_WAIT:  if (cnt == 8'd0) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk156) begin
        if (rst) begin
            bus.db_valid <= 1'b0;
            bus.db_op    <= '0;
            bus.db_hash  <= '0;
            bus.db_key   <= '0;
            bus.db_value <= '0;
            bus.r0_valid <= 1'b0;
            bus.r0_flag  <= '0;
            bus.r0_value <= '0;
            bus.r0_miss  <= 1'b0;
            bus.r1_valid <= 1'b0;
            bus.r1_flag  <= '0;
            bus.r1_value <= '0;
            bus.r1_miss  <= 1'b0;
            cnt          <= 8'd0;
            owner        <= 1'b0;
            got_rsp      <= 1'b0;
        end else begin
            bus.db_valid <= (state == ST_IDLE) && hs;
            bus.r0_valid <= 1'b0;
            bus.r1_valid <= 1'b0;

            if ((state == ST_IDLE) && hs) begin
                owner        <= gnt[1];
                bus.db_op    <= gnt[1] ? bus.p1_op    : bus.p0_op;
                bus.db_hash  <= gnt[1] ? bus.p1_hash  : bus.p0_hash;
                bus.db_key   <= gnt[1] ? bus.p1_key   : bus.p0_key;
                bus.db_value <= gnt[1] ? bus.p1_value : bus.p0_value;
            end

            if (state == ST_ISSUE) begin
                cnt     <= 8'(SLOT_CYCLES - 1);
                got_rsp <= 1'b0;
            end else if ((state == ST_WAIT) && (cnt != 8'd0)) begin
                cnt <= cnt - 8'd1;
            end

            if (rsp_take) begin
                got_rsp <= 1'b1;
                if (owner) begin
                    bus.r1_valid <= 1'b1;
                    bus.r1_flag  <= bus.db_out_flag;
                    bus.r1_value <= bus.db_out_value;
                    bus.r1_miss  <= 1'b0;
                end else begin
                    bus.r0_valid <= 1'b1;
                    bus.r0_flag  <= bus.db_out_flag;
                    bus.r0_value <= bus.db_out_value;
                    bus.r0_miss  <= 1'b0;
                end
            end

            if (miss_take) begin
                if (owner) begin
                    bus.r1_valid <= 1'b1;
                    bus.r1_flag  <= '0;
                    bus.r1_value <= '0;
                    bus.r1_miss  <= 1'b1;
                end else begin
                    bus.r0_valid <= 1'b1;
                    bus.r0_flag  <= '0;
                    bus.r0_value <= '0;
                    bus.r0_miss  <= 1'b1;
                end
            end
        end
    end

`ifdef DB_ARB_STATS_EN
    logic stray_evt;
    assign stray_evt = bus.db_out_valid && !rsp_take;

    always_ff @(posedge clk156) begin
        if (rst) begin
            stat_grant0 <= 32'd0;
            stat_grant1 <= 32'd0;
            stat_stray  <= 16'd0;
        end else begin
            if (bus.p0_valid && gnt[0]) stat_grant0 <= stat_grant0 + 32'd1;
            if (bus.p1_valid && gnt[1]) stat_grant1 <= stat_grant1 + 32'd1;
            if (stray_evt)              stat_stray  <= sat_inc16(stat_stray);
        end
    end
`else
    assign stat_grant0 = 32'd0;
    assign stat_grant1 = 32'd0;
    assign stat_stray  = 16'd0;
`endif

endmodule

// File: tb/tb_db_arb.sv
// Directed bench for db_arb: reset, single GET, tie arbitration, miss, stray
// responses, reset mid-slot and request hold while inputs toggle.
module tb_db_arb;
    import db_pkg::*;

    localparam int HS = 32;
    localparam int KS = 96;
    localparam int VS = 32;
    localparam int SC = 5;

    logic clk156 = 1'b0;
    logic rst    = 1'b1;
    always #5 clk156 = ~clk156;

    db_arb_if #(.HASH_SIZE(HS), .KEY_SIZE(KS), .VAL_SIZE(VS)) bus ();

    logic [31:0] stat_grant0, stat_grant1;
    logic [15:0] stat_stray;

    db_arb #(.HASH_SIZE(HS), .KEY_SIZE(KS), .VAL_SIZE(VS), .SLOT_CYCLES(SC)) dut (
        .clk156      (clk156),
        .rst         (rst),
        .bus         (bus),
        .stat_grant0 (stat_grant0),
        .stat_grant1 (stat_grant1),
        .stat_stray  (stat_stray)
    );

    int checks = 0;
    int errors = 0;
    int n_r0, n_r1, n_dbv;

    task automatic step();
        @(posedge clk156);
        #1;
    endtask

    task automatic idle_inputs();
        bus.p0_valid = 1'b0; bus.p0_op = '0; bus.p0_hash = '0; bus.p0_key = '0; bus.p0_value = '0;
        bus.p1_valid = 1'b0; bus.p1_op = '0; bus.p1_hash = '0; bus.p1_key = '0; bus.p1_value = '0;
        bus.db_out_valid = 1'b0; bus.db_out_flag = '0; bus.db_out_value = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic run_count(input int n);
        for (int i = 0; i < n; i++) begin
            step();
            if (bus.r0_valid) n_r0++;
            if (bus.r1_valid) n_r1++;
            if (bus.db_valid) n_dbv++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        step();
        step();
        checks++; if (bus.db_valid !== 1'b0) begin errors++; $display("FAIL reset_db_valid: got %b want 0", bus.db_valid); end
        checks++; if (bus.db_key !== '0 || bus.db_hash !== '0 || bus.db_op !== '0 || bus.db_value !== '0) begin
            errors++; $display("FAIL reset_db_bus: key %h hash %h op %h value %h want 0", bus.db_key, bus.db_hash, bus.db_op, bus.db_value); end
        checks++; if ({bus.r0_valid, bus.r0_miss, bus.r0_flag, bus.r0_value, bus.r1_valid, bus.r1_miss, bus.r1_flag, bus.r1_value} !== '0) begin
            errors++; $display("FAIL reset_resp: r0 %b/%b/%h/%h r1 %b/%b/%h/%h want 0", bus.r0_valid, bus.r0_miss, bus.r0_flag, bus.r0_value,
                               bus.r1_valid, bus.r1_miss, bus.r1_flag, bus.r1_value); end
        checks++; if ({stat_grant0, stat_grant1, stat_stray} !== '0) begin
            errors++; $display("FAIL reset_stats: g0 %0d g1 %0d stray %0d want 0", stat_grant0, stat_grant1, stat_stray); end
        checks++; if ({bus.p0_ready, bus.p1_ready} !== 2'b00) begin
            errors++; $display("FAIL reset_ready_idle: got %b want 00", {bus.p1_ready, bus.p0_ready}); end
        rst = 1'b0;
    endtask

    task automatic test_single_get();
        do_reset();
        bus.p0_valid = 1'b1; bus.p0_op = 4'b0000; bus.p0_hash = 32'h0000_00A1; bus.p0_key = 96'h1; bus.p0_value = 32'h0;
        #1;
        checks++; if ({bus.p1_ready, bus.p0_ready} !== 2'b01) begin
            errors++; $display("FAIL single_ready: got %b want 01", {bus.p1_ready, bus.p0_ready}); end
        step();
        bus.p0_valid = 1'b0;
        checks++; if (bus.db_valid !== 1'b1 || bus.db_key !== 96'h1 || bus.db_hash !== 32'h0000_00A1 || bus.db_op !== 4'b0000) begin
            errors++; $display("FAIL single_issue: db_valid %b key %h hash %h op %h want 1/1/a1/0", bus.db_valid, bus.db_key, bus.db_hash, bus.db_op); end
        n_r0 = 0; n_r1 = 0; n_dbv = 0;
        run_count(1);
        checks++; if (bus.db_valid !== 1'b0) begin errors++; $display("FAIL single_db_valid_pulse: got %b want 0", bus.db_valid); end
        run_count(2);
        bus.db_out_valid = 1'b1; bus.db_out_flag = 4'b0100; bus.db_out_value = 32'h1234_5678;
        run_count(1);
        bus.db_out_valid = 1'b0; bus.db_out_flag = '0; bus.db_out_value = '0;
        checks++; if (bus.r0_valid !== 1'b1 || bus.r0_flag !== 4'b0100 || bus.r0_value !== 32'h1234_5678 || bus.r0_miss !== 1'b0) begin
            errors++; $display("FAIL single_resp: valid %b flag %b value %h miss %b want 1/0100/12345678/0",
                               bus.r0_valid, bus.r0_flag, bus.r0_value, bus.r0_miss); end
        run_count(SC + 2);
        checks++; if (n_r0 !== 1 || n_r1 !== 0) begin
            errors++; $display("FAIL single_pulse_count: r0 %0d r1 %0d want 1/0", n_r0, n_r1); end
    endtask

    task automatic test_tie();
        int g_port[4];
        int g_cyc[4];
        int ng;
        int both_rdy;
        ng = 0; both_rdy = 0;
        rst = 1'b1;
        idle_inputs();
        bus.p0_valid = 1'b1; bus.p0_key = 96'hA0;
        bus.p1_valid = 1'b1; bus.p1_key = 96'hB1;
        step();
        step();
        rst = 1'b0;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (bus.p0_ready && bus.p1_ready) both_rdy++;
            if (ng < 4 && bus.p0_valid && bus.p0_ready) begin g_port[ng] = 0; g_cyc[ng] = c; ng++; end
            else if (ng < 4 && bus.p1_valid && bus.p1_ready) begin g_port[ng] = 1; g_cyc[ng] = c; ng++; end
            @(posedge clk156);
        end
        #1;
        bus.p0_valid = 1'b0; bus.p1_valid = 1'b0;
        checks++; if (both_rdy !== 0) begin errors++; $display("FAIL tie_both_ready: got %0d cycles want 0", both_rdy); end
        checks++; if (ng !== 4) begin errors++; $display("FAIL tie_grant_count: got %0d want 4", ng); end
        else begin
            checks++; if (g_port[0] !== 0 || g_port[1] !== 1 || g_port[2] !== 0 || g_port[3] !== 1) begin
                errors++; $display("FAIL tie_order: got %0d%0d%0d%0d want 0101", g_port[0], g_port[1], g_port[2], g_port[3]); end
            for (int k = 1; k < 4; k++) begin
                checks++; if (g_cyc[k] - g_cyc[k-1] !== SC + 2) begin
                    errors++; $display("FAIL tie_spacing%0d: got %0d want %0d", k, g_cyc[k] - g_cyc[k-1], SC + 2); end
            end
        end
`ifdef DB_ARB_STATS_EN
        checks++; if (stat_grant0 !== 32'd3 || stat_grant1 !== 32'd3) begin
            errors++; $display("FAIL tie_stats: g0 %0d g1 %0d want 3/3", stat_grant0, stat_grant1); end
`else
        checks++; if (stat_grant0 !== 32'd0 || stat_grant1 !== 32'd0) begin
            errors++; $display("FAIL tie_stats_off: g0 %0d g1 %0d want 0/0", stat_grant0, stat_grant1); end
`endif
    endtask

    task automatic test_miss();
        int rsp_c;
        logic [3:0] rsp_flag;
        logic [31:0] rsp_val;
        logic rsp_miss;
        rsp_c = -1; rsp_flag = 'x; rsp_val = 'x; rsp_miss = 1'bx;
        do_reset();
        bus.db_out_flag = 4'hF; bus.db_out_value = 32'hFFFF_FFFF;
        bus.p1_valid = 1'b1; bus.p1_op = 4'b0011; bus.p1_hash = 32'h5151; bus.p1_key = 96'h77; bus.p1_value = 32'h9999;
        #1;
        checks++; if ({bus.p1_ready, bus.p0_ready} !== 2'b10) begin
            errors++; $display("FAIL miss_ready: got %b want 10", {bus.p1_ready, bus.p0_ready}); end
        step();
        bus.p1_valid = 1'b0;
        n_r0 = 0; n_r1 = 0; n_dbv = 0;
        for (int c = 0; c <= SC + 3; c++) begin
            if (bus.db_valid) n_dbv++;
            if (bus.r0_valid) n_r0++;
            if (bus.r1_valid) begin
                n_r1++;
                rsp_c = c; rsp_flag = bus.r1_flag; rsp_val = bus.r1_value; rsp_miss = bus.r1_miss;
            end
            step();
        end
        checks++; if (n_dbv !== 1) begin errors++; $display("FAIL miss_db_valid_cycles: got %0d want 1", n_dbv); end
        checks++; if (n_r1 !== 1 || n_r0 !== 0) begin errors++; $display("FAIL miss_pulses: r1 %0d r0 %0d want 1/0", n_r1, n_r0); end
        checks++; if (rsp_c !== SC + 1) begin errors++; $display("FAIL miss_timing: got cycle %0d want %0d", rsp_c, SC + 1); end
        checks++; if (rsp_miss !== 1'b1 || rsp_flag !== 4'h0 || rsp_val !== 32'h0) begin
            errors++; $display("FAIL miss_resp: miss %b flag %h value %h want 1/0/0", rsp_miss, rsp_flag, rsp_val); end
    endtask

    task automatic test_stray();
        do_reset();
        bus.db_out_valid = 1'b1; bus.db_out_flag = 4'h7; bus.db_out_value = 32'h77;
        step();
        bus.db_out_valid = 1'b0;
        bus.p0_valid = 1'b1; bus.p0_op = 4'b0000; bus.p0_key = 96'h2; bus.p0_hash = 32'h22;
        step();
        bus.p0_valid = 1'b0;
        step();
        n_r0 = 0; n_r1 = 0; n_dbv = 0;
        bus.db_out_valid = 1'b1; bus.db_out_flag = 4'b0001; bus.db_out_value = 32'hAAAA_0001;
        run_count(1);
        checks++; if (bus.r0_valid !== 1'b1 || bus.r0_flag !== 4'b0001 || bus.r0_value !== 32'hAAAA_0001) begin
            errors++; $display("FAIL stray_first_resp: valid %b flag %b value %h want 1/0001/aaaa0001", bus.r0_valid, bus.r0_flag, bus.r0_value); end
        bus.db_out_flag = 4'b0010; bus.db_out_value = 32'hBBBB_0002;
        run_count(1);
        bus.db_out_valid = 1'b0;
        checks++; if (bus.r0_valid !== 1'b0 || bus.r0_flag !== 4'b0001 || bus.r0_value !== 32'hAAAA_0001) begin
            errors++; $display("FAIL stray_second_dropped: valid %b flag %b value %h want 0/0001/aaaa0001", bus.r0_valid, bus.r0_flag, bus.r0_value); end
        run_count(SC + 2);
        checks++; if (n_r0 !== 1 || n_r1 !== 0) begin errors++; $display("FAIL stray_pulses: r0 %0d r1 %0d want 1/0", n_r0, n_r1); end
`ifdef DB_ARB_STATS_EN
        checks++; if (stat_stray !== 16'd2) begin errors++; $display("FAIL stray_count: got %0d want 2", stat_stray); end
`else
        checks++; if (stat_stray !== 16'd0) begin errors++; $display("FAIL stray_count_off: got %0d want 0", stat_stray); end
`endif
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        bus.p0_valid = 1'b1; bus.p0_op = 4'b0101; bus.p0_hash = 32'h33; bus.p0_key = 96'h3; bus.p0_value = 32'h55;
        step();
        bus.p0_valid = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++; if (bus.db_valid !== 1'b0 || bus.db_key !== '0 || bus.db_hash !== '0 || bus.db_op !== '0 || bus.db_value !== '0) begin
            errors++; $display("FAIL rstwait_db: valid %b key %h hash %h op %h value %h want 0", bus.db_valid, bus.db_key, bus.db_hash, bus.db_op, bus.db_value); end
        checks++; if ({bus.r0_valid, bus.r0_miss, bus.r0_flag, bus.r0_value} !== '0) begin
            errors++; $display("FAIL rstwait_r0: %b/%b/%h/%h want 0", bus.r0_valid, bus.r0_miss, bus.r0_flag, bus.r0_value); end
        n_r0 = 0; n_r1 = 0; n_dbv = 0;
        run_count(SC + 3);
        checks++; if (n_r0 !== 0 || n_r1 !== 0) begin errors++; $display("FAIL rstwait_no_resp: r0 %0d r1 %0d want 0/0", n_r0, n_r1); end
        bus.db_out_valid = 1'b1;
        step();
        bus.db_out_valid = 1'b0;
`ifdef DB_ARB_STATS_EN
        checks++; if (stat_stray !== 16'd1) begin errors++; $display("FAIL rstwait_stray: got %0d want 1", stat_stray); end
`else
        checks++; if (stat_stray !== 16'd0) begin errors++; $display("FAIL rstwait_stray_off: got %0d want 0", stat_stray); end
`endif
        bus.p0_valid = 1'b1; bus.p1_valid = 1'b1;
        #1;
        checks++; if ({bus.p1_ready, bus.p0_ready} !== 2'b01) begin
            errors++; $display("FAIL rstwait_tie: got %b want 01", {bus.p1_ready, bus.p0_ready}); end
        bus.p0_valid = 1'b0; bus.p1_valid = 1'b0;
    endtask

    task automatic test_hold();
        logic [3:0]  e_op;
        logic [31:0] e_hash;
        logic [95:0] e_key;
        logic [31:0] e_val;
        e_op = 4'b0101; e_hash = 32'hCAFE_F00D; e_key = 96'h0123_4567_89AB_CDEF_0011_2233; e_val = 32'h600D_BEEF;
        do_reset();
        bus.p1_valid = 1'b1; bus.p1_op = e_op; bus.p1_hash = e_hash; bus.p1_key = e_key; bus.p1_value = e_val;
        step();
        for (int c = 0; c <= SC; c++) begin
            bus.p0_valid = 1'($urandom); bus.p0_op = 4'($urandom); bus.p0_hash = $urandom;
            bus.p0_key = {$urandom, $urandom, $urandom}; bus.p0_value = $urandom;
            bus.p1_valid = 1'($urandom); bus.p1_op = 4'($urandom); bus.p1_hash = $urandom;
            bus.p1_key = {$urandom, $urandom, $urandom}; bus.p1_value = $urandom;
            #1;
            checks++; if (bus.db_op !== e_op || bus.db_hash !== e_hash || bus.db_key !== e_key || bus.db_value !== e_val) begin
                errors++; $display("FAIL hold_c%0d: op %h hash %h key %h value %h want %h/%h/%h/%h",
                                   c, bus.db_op, bus.db_hash, bus.db_key, bus.db_value, e_op, e_hash, e_key, e_val); end
            step();
        end
        bus.p0_valid = 1'b0; bus.p1_valid = 1'b0;
        checks++; if (bus.r1_valid !== 1'b1 || bus.r1_miss !== 1'b1 || bus.r0_valid !== 1'b0) begin
            errors++; $display("FAIL hold_end_resp: r1_valid %b r1_miss %b r0_valid %b want 1/1/0", bus.r1_valid, bus.r1_miss, bus.r0_valid); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        test_reset();
        test_single_get();
        test_tie();
        test_miss();
        test_stray();
        test_reset_mid_wait();
        test_hold();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
